// File: rtl/proc_io_bank_pkg.sv
// Shared definitions for the processor I/O bank: default widths and pointer sizing.
package proc_io_bank_pkg;

    localparam int unsigned NUBITS_DEF = 32;
    localparam int unsigned FDEPTH_DEF = 4;

    // Ceiling log2; used to size FIFO pointers.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned PTR_W = clog2(FDEPTH_DEF);
    localparam int unsigned CNT_W = PTR_W + 1;

endpackage

// File: rtl/io_fifo.sv
// Single-clock FIFO with occupancy counter. A pop on an empty FIFO is refused;
// a push on a full FIFO is accepted only when a pop happens in the same cycle.
module io_fifo
    import proc_io_bank_pkg::*;
#(
    parameter int unsigned NUBITS = NUBITS_DEF,
    parameter int unsigned FDEPTH = FDEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [NUBITS-1:0]       din,
    output logic [NUBITS-1:0]       dout,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(FDEPTH):0]  count
);

    localparam int unsigned PW = clog2(FDEPTH);
    localparam int unsigned CW = PW + 1;

    logic [NUBITS-1:0] mem [FDEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              do_push;
    logic              do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(FDEPTH));
    assign count   = cnt;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head word is forced to zero while empty so stale storage never shows.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are don't-care until counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/proc_io_bank.sv
// Responder for the processor I/O port protocol: per-port input FIFOs read by
// one-hot req_in, per-port output FIFOs written by one-hot out_en.
module proc_io_bank
    import proc_io_bank_pkg::*;
#(
    parameter int unsigned NUBITS = NUBITS_DEF,
    parameter int unsigned NUIOIN = 2,
    parameter int unsigned NUIOOU = 2,
    parameter int unsigned FDEPTH = FDEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUIOIN-1:0]        req_in,
    output logic [NUBITS-1:0]        io_in,
    input  logic [NUIOOU-1:0]        out_en,
    input  logic [NUBITS-1:0]        io_out,
    input  logic [NUIOIN*NUBITS-1:0] src_data,
    input  logic [NUIOIN-1:0]        src_valid,
    output logic [NUIOIN-1:0]        src_ready,
    output logic [NUIOOU*NUBITS-1:0] snk_data,
    output logic [NUIOOU-1:0]        snk_valid,
    input  logic [NUIOOU-1:0]        snk_ready,
    output logic [NUIOIN-1:0]        err_udf,
    output logic [NUIOOU-1:0]        err_ovf
);

    localparam int unsigned CW = clog2(FDEPTH) + 1;

    logic [NUBITS-1:0] in_dout [NUIOIN];
    logic [NUIOIN-1:0] in_full;
    logic [NUIOIN-1:0] in_empty;
    logic [NUIOOU-1:0] out_full;
    logic [NUIOOU-1:0] out_empty;
    logic [CW-1:0]     in_cnt_unused  [NUIOIN];
    logic [CW-1:0]     out_cnt_unused [NUIOOU];
    logic [NUIOIN-1:0] rd_gnt;
    logic [NUIOIN-1:0] rd_pop;
    logic [NUIOOU-1:0] wr_gnt;
    logic [NUIOOU-1:0] snk_pop;

    for (genvar k = 0; k < NUIOIN; k++) begin : g_in
        io_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (src_valid[k] & src_ready[k]),
            .pop   (rd_pop[k]),
            .din   (src_data[k*NUBITS +: NUBITS]),
            .dout  (in_dout[k]),
            .full  (in_full[k]),
            .empty (in_empty[k]),
            .count (in_cnt_unused[k])
        );
    end

    for (genvar k = 0; k < NUIOOU; k++) begin : g_out
        io_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (wr_gnt[k]),
            .pop   (snk_ready[k]),
            .din   (io_out),
            .dout  (snk_data[k*NUBITS +: NUBITS]),
            .full  (out_full[k]),
            .empty (out_empty[k]),
            .count (out_cnt_unused[k])
        );
    end

    assign src_ready = ~in_full;
    assign snk_valid = ~out_empty;
    assign snk_pop   = snk_ready & ~out_empty;
    assign rd_pop    = rd_gnt & ~in_empty;

    // Lowest-index priority grant for read requests and write enables.
    always_comb begin
        rd_gnt = '0;
        wr_gnt = '0;
        for (int unsigned k = 0; k < NUIOIN; k++) begin
            if (req_in[k] && rd_gnt == '0) rd_gnt[k] = 1'b1;
        end
        for (int unsigned k = 0; k < NUIOOU; k++) begin
            if (out_en[k] && wr_gnt == '0) wr_gnt[k] = 1'b1;
        end
    end

    // Zero-latency read mux: granted, non-empty port drives its head word.
    always_comb begin
        io_in = '0;
        for (int unsigned k = 0; k < NUIOIN; k++) begin
            if (rd_pop[k]) io_in = in_dout[k];
        end
    end

    // Sticky underflow/overflow flags; a write to a full FIFO is legal only
    // when the consumer frees a slot in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_udf <= '0;
            err_ovf <= '0;
        end else begin
            err_udf <= err_udf | (rd_gnt & in_empty);
            err_ovf <= err_ovf | (wr_gnt & out_full & ~snk_pop);
        end
    end

endmodule
